// File: rtl/branch_resolution_queue.sv
// -----------------------------------------------------------------------------
// branch_resolution_queue
//
// Purpose:
//   In-order queue of predicted branches waiting for execute to resolve them.
//   Fetch/predict pushes {pc, predicted direction}. Execute reports the actual
//   outcome of the oldest entry, and that entry pops. Each resolution drives a
//   one-cycle registered update to the gshare predictor. A mispredict discards
//   every younger entry.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-high reset
//   enq_valid/enq_pc/enq_pred_taken/enq_ready
//                       push side (enq_ready = !full)
//   res_valid/res_taken resolve side for the oldest entry
//   flush_in            external flush; discards all entries and has priority
//                       over a push or resolve in the same cycle
//   update_valid/update_pc/update_taken/update_predicted
//                       registered predictor-update pulse, one cycle after a
//                       resolve
//   mispredict          registered pulse, coincident with update_valid
//   res_err             registered pulse: a resolve arrived while empty
//   full/empty/count    occupancy status
//
// Optional feature (macro BRQ_STATS_EN):
//   Adds the saturating 16-bit counters stat_branches and stat_mispredicts.
// -----------------------------------------------------------------------------
module branch_resolution_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  input  logic [31:0]      enq_pc,
  input  logic             enq_pred_taken,
  output logic             enq_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic             flush_in,
  output logic             update_valid,
  output logic [31:0]      update_pc,
  output logic             update_taken,
  output logic             update_predicted,
  output logic             mispredict,
  output logic             res_err,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
`ifdef BRQ_STATS_EN
  ,
  output logic [15:0]      stat_branches,
  output logic [15:0]      stat_mispredicts
`endif
);

  logic [31:0]      pc_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_nxt;

  logic             enq_fire_p0;
  logic             res_fire_p0;
  logic             mis_p0;
  logic             enq_do_p0;
  logic             head_pred_p0;
  logic [31:0]      head_pc_p0;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign enq_ready = !full;

  assign head_pc_p0   = pc_mem[rd_ptr];
  assign head_pred_p0 = pred_mem[rd_ptr];

  // Flush wins over everything; a mispredicting resolve also swallows any
  // push in the same cycle, so the write pointer must not advance then.
  assign enq_fire_p0 = enq_valid && enq_ready && !flush_in;
  assign res_fire_p0 = res_valid && !empty && !flush_in;
  assign mis_p0      = res_fire_p0 && (res_taken != head_pred_p0);
  assign enq_do_p0   = enq_fire_p0 && !mis_p0;

  always_comb begin
    count_nxt = count;
    if (flush_in || mis_p0) begin
      count_nxt = '0;
    end else begin
      case ({enq_do_p0, res_fire_p0})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // Entry storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (enq_do_p0 && !rst) begin
      pc_mem[wr_ptr]   <= enq_pc;
      pred_mem[wr_ptr] <= enq_pred_taken;
    end
  end

  // Stage p0 -> p1: queue control state and registered update outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      update_valid     <= 1'b0;
      update_pc        <= '0;
      update_taken     <= 1'b0;
      update_predicted <= 1'b0;
      mispredict       <= 1'b0;
      res_err          <= 1'b0;
    end else begin
      count        <= count_nxt;
      update_valid <= res_fire_p0;
      mispredict   <= mis_p0;
      res_err      <= res_valid && empty && !flush_in;

      if (enq_do_p0) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      // Discarding everything means the read side catches up with the
      // write side; the write pointer is left where it is.
      if (flush_in || mis_p0) begin
        rd_ptr <= wr_ptr;
      end else if (res_fire_p0) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (res_fire_p0) begin
        update_pc        <= head_pc_p0;
        update_taken     <= res_taken;
        update_predicted <= head_pred_p0;
      end
    end
  end

`ifdef BRQ_STATS_EN
  // Counters watch the registered pulses, so they lag one cycle behind them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (update_valid && (stat_branches != 16'hFFFF)) begin
        stat_branches <= stat_branches + 16'd1;
      end
      if (mispredict && (stat_mispredicts != 16'hFFFF)) begin
        stat_mispredicts <= stat_mispredicts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolution_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_resolution_queue
//
// Purpose:
//   Directed self-checking bench for branch_resolution_queue. It covers reset,
//   fill/drain ordering with pointer wrap, mispredict flush, same-cycle push
//   and resolve, empty resolve, flush priority, reset while busy, and the
//   optional statistics counters (when BRQ_STATS_EN is defined).
// -----------------------------------------------------------------------------
module tb_branch_resolution_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic [31:0] enq_pc;
  logic        enq_pred_taken;
  logic        enq_ready;
  logic        res_valid;
  logic        res_taken;
  logic        flush_in;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_predicted;
  logic        mispredict;
  logic        res_err;
  logic        full;
  logic        empty;
  logic [3:0]  count;
`ifdef BRQ_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolution_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .enq_valid        (enq_valid),
    .enq_pc           (enq_pc),
    .enq_pred_taken   (enq_pred_taken),
    .enq_ready        (enq_ready),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .flush_in         (flush_in),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_predicted (update_predicted),
    .mispredict       (mispredict),
    .res_err          (res_err),
    .full             (full),
    .empty            (empty),
    .count            (count)
`ifdef BRQ_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid = 1'b0; res_valid = 1'b0; flush_in = 1'b0;
    enq_pc = '0; enq_pred_taken = 1'b0; res_taken = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pred);
    enq_valid = 1'b1; enq_pc = pc; enq_pred_taken = pred;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (update_valid !== 1'b0) begin errors++; $display("FAIL reset_update_valid: got %b expected 0", update_valid); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %b expected 0", mispredict); end
  endtask

  // Fill eight entries (pred T,N,T,N...), then resolve all with matching outcomes.
  task automatic fill_drain(input string tag);
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_before: got %b expected 1", tag, enq_ready); end
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(4 * i), (i % 2) == 0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL %s_full: got %b expected 1", tag, full); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL %s_enq_ready: got %b expected 0", tag, enq_ready); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL %s_count_full: got %0d expected 8", tag, count); end
    for (int i = 0; i < 8; i++) begin
      res_valid = 1'b1; res_taken = ((i % 2) == 0);
      tick();
      checks++; if (update_valid !== 1'b1) begin errors++; $display("FAIL %s_uv[%0d]: got %b expected 1", tag, i, update_valid); end
      checks++; if (update_pc !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL %s_pc[%0d]: got %h expected %h", tag, i, update_pc, 32'h100 + 32'(4 * i)); end
      checks++; if (update_predicted !== ((i % 2) == 0)) begin errors++; $display("FAIL %s_pred[%0d]: got %b expected %b", tag, i, update_predicted, (i % 2) == 0); end
      checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL %s_mis[%0d]: got %b expected 0", tag, i, mispredict); end
    end
    res_valid = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL %s_empty: got %b expected 1", tag, empty); end
    tick();
    checks++; if (update_valid !== 1'b0) begin errors++; $display("FAIL %s_uv_idle: got %b expected 0", tag, update_valid); end
  endtask

  task automatic test_fill_drain();
    fill_drain("fill1");
    fill_drain("wrap");
  endtask

  task automatic test_mispredict();
    push(32'h200, 1'b1);
    push(32'h204, 1'b0);
    push(32'h208, 1'b1);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL mis_count_pre: got %0d expected 3", count); end
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    checks++; if (update_valid !== 1'b1) begin errors++; $display("FAIL mis_uv: got %b expected 1", update_valid); end
    checks++; if (update_pc !== 32'h200) begin errors++; $display("FAIL mis_pc: got %h expected 200", update_pc); end
    checks++; if (update_taken !== 1'b0) begin errors++; $display("FAIL mis_taken: got %b expected 0", update_taken); end
    checks++; if (update_predicted !== 1'b1) begin errors++; $display("FAIL mis_pred: got %b expected 1", update_predicted); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", mispredict); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mis_count: got %0d expected 0", count); end
    tick();
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b expected 0", mispredict); end
    checks++; if (update_pc !== 32'h200) begin errors++; $display("FAIL mis_pc_hold: got %h expected 200", update_pc); end
    // Mispredict also discards a push in the same cycle.
    push(32'h210, 1'b1);
    res_valid = 1'b1; res_taken = 1'b0;
    enq_valid = 1'b1; enq_pc = 32'h214; enq_pred_taken = 1'b0;
    tick();
    idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mis_enq_count: got %0d expected 0", count); end
    checks++; if (update_pc !== 32'h210) begin errors++; $display("FAIL mis_enq_pc: got %h expected 210", update_pc); end
  endtask

  task automatic test_back_to_back();
    push(32'h2F0, 1'b0);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL b2b_count_pre: got %0d expected 1", count); end
    res_valid = 1'b1; res_taken = 1'b0;
    enq_valid = 1'b1; enq_pc = 32'h300; enq_pred_taken = 1'b1;
    tick();
    idle();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", count); end
    checks++; if (update_pc !== 32'h2F0) begin errors++; $display("FAIL b2b_pc0: got %h expected 2f0", update_pc); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL b2b_mis0: got %b expected 0", mispredict); end
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    checks++; if (update_pc !== 32'h300) begin errors++; $display("FAIL b2b_pc1: got %h expected 300", update_pc); end
    checks++; if (update_predicted !== 1'b1) begin errors++; $display("FAIL b2b_pred1: got %b expected 1", update_predicted); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL b2b_count_end: got %0d expected 0", count); end
  endtask

  task automatic test_empty_flush();
    tick();
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL empty_res_err: got %b expected 1", res_err); end
    checks++; if (update_valid !== 1'b0) begin errors++; $display("FAIL empty_uv: got %b expected 0", update_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", count); end
    tick();
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL empty_res_err_end: got %b expected 0", res_err); end
    push(32'h400, 1'b1);
    push(32'h404, 1'b0);
    flush_in = 1'b1; res_valid = 1'b1; res_taken = 1'b1;
    enq_valid = 1'b1; enq_pc = 32'h408; enq_pred_taken = 1'b1;
    tick();
    idle();
    checks++; if (update_valid !== 1'b0) begin errors++; $display("FAIL flush_uv: got %b expected 0", update_valid); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL flush_res_err: got %b expected 0", res_err); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", empty); end
    // Queue keeps working correctly after the flush.
    push(32'h500, 1'b0);
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    checks++; if (update_pc !== 32'h500) begin errors++; $display("FAIL flush_after_pc: got %h expected 500", update_pc); end
  endtask

  task automatic test_reset_mid();
    push(32'h600, 1'b1);
    push(32'h604, 1'b1);
    rst = 1'b1; res_valid = 1'b1; res_taken = 1'b0;
    tick();
    rst = 1'b0; res_valid = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    checks++; if (update_valid !== 1'b0) begin errors++; $display("FAIL rstmid_uv: got %b expected 0", update_valid); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL rstmid_mis: got %b expected 0", mispredict); end
    checks++; if (update_pc !== 32'h0) begin errors++; $display("FAIL rstmid_pc: got %h expected 0", update_pc); end
  endtask

`ifdef BRQ_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(32'h700, 1'b1);
    push(32'h704, 1'b0);
    push(32'h708, 1'b1);
    res_valid = 1'b1; res_taken = 1'b1; tick();
    res_valid = 1'b1; res_taken = 1'b0; tick();
    res_valid = 1'b1; res_taken = 1'b0; tick();
    res_valid = 1'b0;
    tick();
    checks++; if (stat_branches !== 16'd3) begin errors++; $display("FAIL stat_branches: got %0d expected 3", stat_branches); end
    checks++; if (stat_mispredicts !== 16'd1) begin errors++; $display("FAIL stat_mispredicts: got %0d expected 1", stat_mispredicts); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (stat_branches !== 16'd0) begin errors++; $display("FAIL stat_branches_rst: got %0d expected 0", stat_branches); end
    checks++; if (stat_mispredicts !== 16'd0) begin errors++; $display("FAIL stat_mispredicts_rst: got %0d expected 0", stat_mispredicts); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fill_drain();
    test_mispredict();
    test_back_to_back();
    test_empty_flush();
    test_reset_mid();
`ifdef BRQ_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
